gpu_pixel_serializer: RTL and testbench
=======================================

GPU_PIXEL_SERIALIZER -- requirements
Module: gpu_pixel_serializer

Interface
REQ-001 SHALL have parameter PIPE_DELAY, default 1: cycles from a slot cycle to its registered outputs; only 1 is supported.
REQ-002 SHALL have port clk, input, 1: the single clock; all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port pc_ena_in, input, 4: sub-pixel phase from the RAM stage; a pixel slot is a cycle with pc_ena_in==0.
REQ-005 SHALL have port cmd_in, input, 32: control word from the RAM stage.
- [31] load
- [30] window active
- [29] underrun clear
- [15:8] palette offset
- [7:4] hrepeat (repeat count minus 1)
- [1:0] mode: 0=1bpp, 1=2bpp, 2=4bpp, 3=8bpp
- other bits carried, not decoded
REQ-006 SHALL have port data_in, input, 16: pixel word, byte-ordered by the RAM stage.
REQ-007 SHALL have port pixel_out, output, 8: palette index.
REQ-008 SHALL have port pixel_valid, output, 1: pixel_out came from word data.
REQ-009 SHALL have port pc_ena_out, output, 4: pc_ena_in delayed 1 cycle.
REQ-010 SHALL have port cmd_out, output, 32: cmd_in delayed 1 cycle.
REQ-011 SHALL have port underrun, output, 1: sticky starvation flag.

Function
REQ-012 SHALL act only on slot cycles; on non-slot cycles it SHALL hold shifter, counters, pixel_out and pixel_valid.
REQ-013 SHALL load a slot with window=1 and load=1:
- shifter <= data_in
- mode latched
- remaining <= 16/bpp (16, 8, 4 or 2)
- repeat counter <= hrepeat
- palette offset latched
REQ-014 SHALL emit, on every slot with window=1 and remaining>0 after any load:
- pixel_out <= (shifter[15 -: bpp] zero-extended + offset) mod 256
- pixel_valid <= 1
REQ-015 A load slot SHALL emit the first pixel of the new word in the same slot (load has priority over draining).
REQ-016 After each emission: if repeat counter==0, SHALL shift left by bpp, decrement remaining and reload repeat from the latched hrepeat; otherwise SHALL decrement the repeat counter only.
REQ-017 A load arriving with remaining>0 SHALL discard the unsent pixels without flagging an error.
REQ-018 On a slot with window=1, remaining==0 and no load, SHALL output pixel_out<=offset, pixel_valid<=0 and set underrun.
REQ-019 On a slot with window=0, SHALL output pixel_out<=0, pixel_valid<=0, clear remaining, and leave underrun unchanged.
REQ-020 SHALL clear underrun on any cycle with cmd_in[29]=1; if the same cycle also sets it, set wins.
REQ-021 Latency SHALL be exactly 1 cycle from the slot cycle to pixel_out/pixel_valid, aligned with pc_ena_out and cmd_out.
REQ-022 Offset addition SHALL wrap modulo 256; no saturation.

Reset
REQ-023 While rst_n=0, all outputs, shifter, counters and the latched mode/offset SHALL be 0 (remaining=0).
REQ-024 Assertion of rst_n mid-word SHALL abandon the word immediately.
REQ-025 The first slot after reset without a load and with window=1 SHALL flag underrun.

Structure
REQ-026 A shared package gpu_pkg SHALL hold:
- cmd bit-position constants (LOAD, WINDOW, UCLR, offset and hrepeat fields)
- the mode enum (1/2/4/8 bpp)
- a bpp-from-mode function
REQ-027 SHALL be a single flat module with no sub-module; 1 shifter, 5-bit remaining counter and 4-bit repeat counter.

Verification
REQ-028 1bpp, offset 0x10, hrepeat 0, data 0xA5F0, load then 15 further slots:
- pixel_out 0x11,0x10,0x11,0x10,0x10,0x11,0x10,0x11, then 0x11 x4, 0x10 x4
- all pixel_valid=1
- no underrun
REQ-029 4bpp, hrepeat 1, data 0x12F0, offset 0xF8: pixel_out 0xF9,0xF9,0xFA,0xFA,0x07,0x07,0xF8,0xF8 (wrap checked).
REQ-030 8bpp, data 0xABCD, no further load:
- slots 1-2 give 0xAB, 0xCD
- slot 3 gives pixel_valid=0, pixel_out=offset, underrun=1
- cmd_in[29] pulse clears underrun
REQ-031 2bpp load with new load on its 3rd slot: the new word's first pixel appears on that slot; remaining restarts at 8; no underrun.
REQ-032 pc_ena_in cycling 0..3 with loads only at phase 0: outputs change only one cycle after phase-0 cycles; pc_ena_out/cmd_out trail the inputs by exactly 1 cycle.
REQ-033 rst_n low mid-word (4bpp, 2 pixels sent):
- all outputs 0 asynchronously
- after release, first slot with window=1 and no load gives underrun=1

Source files
------------

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared command-word field positions, pixel mode enum and bpp helper
package gpu_pkg;
    localparam int LOAD_BIT = 31;
    localparam int WIN_BIT  = 30;
    localparam int UCLR_BIT = 29;
    localparam int OFF_HI   = 15;
    localparam int OFF_LO   = 8;
    localparam int HREP_HI  = 7;
    localparam int HREP_LO  = 4;
    localparam int MODE_HI  = 1;
    localparam int MODE_LO  = 0;

    typedef enum logic [1:0] {
        MODE_1BPP = 2'd0,
        MODE_2BPP = 2'd1,
        MODE_4BPP = 2'd2,
        MODE_8BPP = 2'd3
    } mode_e;

    function automatic logic [3:0] bpp_of(input mode_e m);
        return 4'd1 << m;
    endfunction
endpackage

// File: rtl/gpu_pixel_serializer.sv
// gpu_pixel_serializer: turns 16-bit pixel words into palette indices, one per
// pixel slot, with horizontal repeat and a sticky starvation flag.
module gpu_pixel_serializer
    import gpu_pkg::*;
#(
    parameter int PIPE_DELAY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  pc_ena_in,
    input  logic [31:0] cmd_in,
    input  logic [15:0] data_in,
    output logic [7:0]  pixel_out,
    output logic        pixel_valid,
    output logic [3:0]  pc_ena_out,
    output logic [31:0] cmd_out,
    output logic        underrun
);
    if (PIPE_DELAY != 1) begin : g_bad_delay
        $error("gpu_pixel_serializer supports only PIPE_DELAY == 1");
    end

    logic [15:0] shifter;
    mode_e       mode;
    logic [4:0]  remaining;
    logic [3:0]  rep;
    logic [3:0]  hrep;
    logic [7:0]  offset;

    logic        slot, win, ld, emit, adv, set_und;
    mode_e       m_eff;
    logic [15:0] src;
    logic [7:0]  off_eff, pix;
    logic [3:0]  hr_eff, rep_eff, bpp;
    logic [4:0]  rem_eff;

    // A load is folded into the same slot: the "effective" values are what the
    // emission logic sees, whether they come from the new word or latched state.
    always_comb begin
        slot    = pc_ena_in == 4'd0;
        win     = cmd_in[WIN_BIT];
        ld      = win & cmd_in[LOAD_BIT];
        m_eff   = ld ? mode_e'(cmd_in[MODE_HI:MODE_LO]) : mode;
        src     = ld ? data_in : shifter;
        off_eff = ld ? cmd_in[OFF_HI:OFF_LO] : offset;
        hr_eff  = ld ? cmd_in[HREP_HI:HREP_LO] : hrep;
        rem_eff = ld ? 5'd16 >> m_eff : remaining;
        rep_eff = ld ? hr_eff : rep;
        bpp     = bpp_of(m_eff);
        pix     = (src[15:8] >> (4'd8 - bpp)) + off_eff;
        emit    = win && rem_eff != 5'd0;
        adv     = rep_eff == 4'd0;
        set_und = slot && win && !emit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shifter     <= '0;
            mode        <= MODE_1BPP;
            remaining   <= '0;
            rep         <= '0;
            hrep        <= '0;
            offset      <= '0;
            pixel_out   <= '0;
            pixel_valid <= 1'b0;
            pc_ena_out  <= '0;
            cmd_out     <= '0;
            underrun    <= 1'b0;
        end else begin
            pc_ena_out <= pc_ena_in;
            cmd_out    <= cmd_in;
            underrun   <= set_und | (underrun & ~cmd_in[UCLR_BIT]);
            if (slot) begin
                if (!win) begin
                    pixel_out   <= '0;
                    pixel_valid <= 1'b0;
                    remaining   <= '0;
                end else if (emit) begin
                    pixel_out   <= pix;
                    pixel_valid <= 1'b1;
                    mode        <= m_eff;
                    offset      <= off_eff;
                    hrep        <= hr_eff;
                    shifter     <= adv ? src << bpp : src;
                    remaining   <= adv ? rem_eff - 5'd1 : rem_eff;
                    rep         <= adv ? hr_eff : rep_eff - 4'd1;
                end else begin
                    pixel_out   <= offset;
                    pixel_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_gpu_pixel_serializer.sv
// tb_gpu_pixel_serializer: directed scenarios plus random traffic, checked
// against a queue-based model of the pixel stream.
module tb_gpu_pixel_serializer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  pc_ena_in = '0;
    logic [31:0] cmd_in = '0;
    logic [15:0] data_in = '0;
    logic [7:0]  pixel_out;
    logic        pixel_valid;
    logic [3:0]  pc_ena_out;
    logic [31:0] cmd_out;
    logic        underrun;

    gpu_pixel_serializer #(.PIPE_DELAY(1)) dut (
        .clk(clk), .rst_n(rst_n), .pc_ena_in(pc_ena_in), .cmd_in(cmd_in),
        .data_in(data_in), .pixel_out(pixel_out), .pixel_valid(pixel_valid),
        .pc_ena_out(pc_ena_out), .cmd_out(cmd_out), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Model: on a load the whole word is expanded into the exact sequence of
    // palette indices it will produce (repeats included).
    logic [7:0]  q[$];
    logic [7:0]  m_off = '0;
    logic [7:0]  e_pix = '0;
    logic        e_val = 1'b0;
    logic        e_und = 1'b0;
    logic [3:0]  e_pc = '0;
    logic [31:0] e_cmd = '0;

    function automatic logic [31:0] mk(input bit load, input bit win, input bit uclr,
                                       input int off, input int hr, input int mode);
        logic [31:0] c;
        c = '0;
        c[31] = load;
        c[30] = win;
        c[29] = uclr;
        c[15:8] = off[7:0];
        c[7:4] = hr[3:0];
        c[1:0] = mode[1:0];
        return c;
    endfunction

    task automatic model_reset();
        q.delete();
        m_off = '0; e_pix = '0; e_val = 1'b0; e_und = 1'b0; e_pc = '0; e_cmd = '0;
    endtask

    task automatic model_step(input logic [3:0] pc, input logic [31:0] cmd, input logic [15:0] data);
        bit set;
        int bpp, n, f;
        set = 0;
        if (pc == 0) begin
            if (!cmd[30]) begin
                e_pix = 0; e_val = 0; q.delete();
            end else begin
                if (cmd[31]) begin
                    q.delete();
                    m_off = cmd[15:8];
                    bpp = 1 << cmd[1:0];
                    n = 16 / bpp;
                    for (int i = 0; i < n; i++) begin
                        f = (int'(data) >> (16 - bpp * (i + 1))) % (1 << bpp);
                        for (int r = 0; r <= int'(cmd[7:4]); r++)
                            q.push_back(8'((f + int'(m_off)) % 256));
                    end
                end
                if (q.size() > 0) begin
                    e_pix = q.pop_front(); e_val = 1;
                end else begin
                    e_pix = m_off; e_val = 0; set = 1;
                end
            end
        end
        e_und = set | (e_und & !cmd[29]);
        e_pc = pc;
        e_cmd = cmd;
    endtask

    task automatic drive(input string tag, input logic [3:0] pc, input logic [31:0] cmd,
                         input logic [15:0] data);
        pc_ena_in = pc; cmd_in = cmd; data_in = data;
        model_step(pc, cmd, data);
        @(posedge clk);
        #1;
        chk({tag, ".pix"}, 32'(pixel_out), 32'(e_pix));
        chk({tag, ".val"}, 32'(pixel_valid), 32'(e_val));
        chk({tag, ".und"}, 32'(underrun), 32'(e_und));
        chk({tag, ".pc"}, 32'(pc_ena_out), 32'(e_pc));
        chk({tag, ".cmd"}, cmd_out, e_cmd);
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".pix"}, 32'(pixel_out), 0);
        chk({tag, ".val"}, 32'(pixel_valid), 0);
        chk({tag, ".und"}, 32'(underrun), 0);
        chk({tag, ".pc"}, 32'(pc_ena_out), 0);
        chk({tag, ".cmd"}, cmd_out, 0);
    endtask

    logic [7:0] exp28[16] = '{8'h11, 8'h10, 8'h11, 8'h10, 8'h10, 8'h11, 8'h10, 8'h11,
                              8'h11, 8'h11, 8'h11, 8'h11, 8'h10, 8'h10, 8'h10, 8'h10};
    logic [7:0] exp29[8] = '{8'hF9, 8'hF9, 8'hFA, 8'hFA, 8'h07, 8'h07, 8'hF8, 8'hF8};

    initial begin
        pc_ena_in = 4'd3; cmd_in = 32'hFFFF_FFFF; data_in = 16'hFFFF;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        model_reset();

        // 1bpp walk with hard-coded expected indices
        drive("b1_load", 0, mk(1, 1, 0, 8'h10, 0, 0), 16'hA5F0);
        chk("b1_k0", 32'(pixel_out), 32'(exp28[0]));
        for (int i = 1; i < 16; i++) begin
            drive("b1", 0, mk(0, 1, 0, 8'h55, 0, 0), 16'h0);
            chk("b1_k", 32'(pixel_out), 32'(exp28[i]));
        end
        chk("b1_noUnd", 32'(underrun), 0);

        // 4bpp with repeat and offset wrap
        drive("b4_load", 0, mk(1, 1, 1, 8'hF8, 1, 2), 16'h12F0);
        chk("b4_k0", 32'(pixel_out), 32'(exp29[0]));
        for (int i = 1; i < 8; i++) begin
            drive("b4", 0, mk(0, 1, 0, 0, 0, 0), 16'h0);
            chk("b4_k", 32'(pixel_out), 32'(exp29[i]));
        end

        // 8bpp then starvation, then clear
        drive("b8_load", 0, mk(1, 1, 0, 8'h00, 0, 3), 16'hABCD);
        chk("b8_k0", 32'(pixel_out), 32'hAB);
        drive("b8", 0, mk(0, 1, 0, 0, 0, 0), 16'h0);
        chk("b8_k1", 32'(pixel_out), 32'hCD);
        drive("b8_starve", 0, mk(0, 1, 0, 0, 0, 0), 16'h0);
        chk("b8_und", 32'(underrun), 1);
        chk("b8_valid0", 32'(pixel_valid), 0);
        drive("uclr", 2, mk(0, 1, 1, 0, 0, 0), 16'h0);
        chk("uclr_und", 32'(underrun), 0);

        // 2bpp reload on the third slot
        drive("b2_load", 0, mk(1, 1, 0, 8'h20, 0, 1), 16'hE400);
        drive("b2", 0, mk(0, 1, 0, 0, 0, 0), 16'h0);
        drive("b2_reload", 0, mk(1, 1, 0, 8'h20, 0, 1), 16'h4000);
        chk("b2_first", 32'(pixel_out), 32'h21);
        for (int i = 1; i < 8; i++) drive("b2_rest", 0, mk(0, 1, 0, 0, 0, 0), 16'h0);
        chk("b2_noUnd", 32'(underrun), 0);
        drive("b2_end", 0, mk(0, 1, 1, 0, 0, 0), 16'h0);

        // phase cycling with loads only at phase 0
        for (int w = 0; w < 3; w++)
            for (int p = 0; p < 4; p++)
                drive("phase", 4'(p), p == 0 ? mk(1, 1, 0, 8'h40, 0, 3) | 32'h00F0_0000 : mk(1, 1, 0, 8'h40, 0, 3) & ~32'h8000_0000,
                      16'(32'h1234 + w * 32'h1111 + p));

        // asynchronous reset mid-word
        drive("rst_a", 0, mk(1, 1, 0, 8'h08, 0, 2), 16'h9876);
        drive("rst_b", 0, mk(0, 1, 0, 0, 0, 0), 16'h0);
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive("post_rst", 0, mk(0, 1, 0, 0, 0, 0), 16'h0);
        chk("post_rst_und", 32'(underrun), 1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] c;
            logic [3:0] pc;
            c = $urandom;
            c[30] = ($urandom % 8) != 0;
            c[31] = ($urandom % 4) == 0;
            c[29] = ($urandom % 16) == 0;
            pc = ($urandom % 2) != 0 ? 4'd0 : 4'($urandom_range(1, 15));
            drive("rnd", pc, c, 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
